// File: rtl/fib_engine.sv
// fib_engine: iterative Fibonacci responder with a strobe/busy/done handshake.
// Results wider than W bits saturate to all-ones and raise ovf.
module fib_engine #(
  parameter int W  = 8,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          stb,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  fib,
  output logic          ovf
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          a_ovf;
  logic          b_ovf;
  logic [NW-1:0] rem;

  logic [W:0]    sum;
  logic          carry;
  logic [W-1:0]  b_sat;

  // Next F(i+2) with one extra bit to catch the carry; once either operand
  // has saturated, every later term is saturated as well.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    carry = sum[W];
    b_sat = (carry || a_ovf || b_ovf) ? {W{1'b1}} : sum[W-1:0];
  end

  // Handshake FSM: accept a request in IDLE, iterate rem times in CALC,
  // then publish a (= F(n)) and its overflow marker for one done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      a_ovf <= 1'b0;
      b_ovf <= 1'b0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fib   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (stb && ena) begin
            rem   <= n;
            a     <= '0;
            b     <= {{(W-1){1'b0}}, 1'b1};
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (rem != '0) begin
            a     <= b;
            a_ovf <= b_ovf;
            b     <= b_sat;
            b_ovf <= b_ovf | a_ovf | carry;
            rem   <= rem - 1'b1;
          end else begin
            fib   <= a;
            ovf   <= a_ovf;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_engine.sv
// tb_fib_engine: directed stimulus, a transaction-level reference model
// checked every cycle, plus literal expectations for specific requests.
module tb_fib_engine;

  localparam int W  = 8;
  localparam int NW = 8;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          stb;
  logic [NW-1:0] n;
  logic          busy;
  logic          done;
  logic [W-1:0]  fib;
  logic          ovf;

  int total;
  int bad;
  int cyc;
  bit check_en;

  fib_engine #(.W(W), .NW(NW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .stb  (stb),
    .n    (n),
    .busy (busy),
    .done (done),
    .fib  (fib),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference F(k): wide arithmetic, terms clamped just above the W-bit limit.
  function automatic void fib_ref(input int k, output int val, output bit o);
    longint lim, x, y, t;
    lim = (64'd1 << W) - 1;
    x = 0;
    y = 1;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      if (t > lim) t = lim + 1;
      x = y;
      y = t;
    end
    o   = (x > lim);
    val = o ? int'(lim) : int'(x);
  endfunction

  // Reference model: an accepted request keeps busy for n+1 cycles, then
  // delivers F(n) with a single done pulse.
  bit m_busy, m_done, m_ovf, p_ovf;
  int m_fib, m_cnt, p_fib;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_fib = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy = 0; m_done = 1; m_fib = p_fib; m_ovf = p_ovf;
        end else begin
          m_cnt--;
        end
      end else if (stb && ena) begin
        m_busy = 1;
        m_cnt  = int'(n);
        fib_ref(int'(n), p_fib, p_ovf);
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (busy !== m_busy || done !== m_done || fib !== W'(m_fib) || ovf !== m_ovf) begin
        bad++;
        $display("FAIL model cyc=%0d got busy=%b done=%b fib=%0d ovf=%b want busy=%b done=%b fib=%0d ovf=%b",
                 cyc, busy, done, fib, ovf, m_busy, m_done, m_fib, m_ovf);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Pulse stb for one accepting edge, then wait for done; returns busy cycle count.
  task automatic request(input int idx, output int busy_cycles, output bit seen);
    @(posedge clk); #2;
    n = NW'(idx); stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
    busy_cycles = 0;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic run_req(input string name, input int idx, input int exp_fib, input int exp_ovf);
    int bc; bit seen;
    request(idx, bc, seen);
    chk({name, "_done"}, int'(seen), 1);
    chk({name, "_fib"}, int'(fib), exp_fib);
    chk({name, "_ovf"}, int'(ovf), exp_ovf);
    chk({name, "_busy_cycles"}, bc, idx + 1);
    $display("req n=%0d fib=%0d ovf=%b busy_cycles=%0d", idx, fib, ovf, bc);
  endtask

  initial begin
    int exp_tbl [10];
    int bc, dcount, t0, t1, t2;
    bit seen;
    exp_tbl = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    total = 0; bad = 0; cyc = 0; check_en = 0;
    rst_n = 1'b0; ena = 1'b1; stb = 1'b0; n = '0;

    // Reset
    @(posedge clk); #2;
    check_en = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_fib", int'(fib), 0);
    chk("reset_ovf", int'(ovf), 0);
    $display("reset busy=%b done=%b fib=%0d ovf=%b", busy, done, fib, ovf);

    // n = 0..9
    for (int i = 0; i < 10; i++) run_req("seq", i, exp_tbl[i], 0);

    // n = 10 with an ignored strobe mid-computation
    @(posedge clk); #2;
    n = 8'd10; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
    bc = 0; seen = 0; dcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 4) begin
        @(posedge clk); #2; n = 8'd3; stb = 1'b1;
        @(posedge clk); #2; stb = 1'b0;
        @(negedge clk);
        if (busy) bc += 2;
      end
      if (done) begin seen = 1; break; end
      if (busy) bc++;
    end
    chk("n10_done", int'(seen), 1);
    chk("n10_fib", int'(fib), 55);
    chk("n10_busy_cycles", bc, 11);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("n10_no_extra_done", dcount, 0);
    chk("n10_fib_hold", int'(fib), 55);
    $display("req n=10 with ignored stb fib=%0d busy_cycles=%0d", fib, bc);

    // Overflow boundary and maximum index
    run_req("n13", 13, 233, 0);
    run_req("n14", 14, 255, 1);
    run_req("n255", 255, 255, 1);

    // Reset in the middle of n=20
    @(posedge clk); #2;
    n = 8'd20; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_fib", int'(fib), 0);
    chk("midrst_ovf", int'(ovf), 0);
    dcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("midrst_quiet", dcount, 0);
    $display("mid-calc reset outputs busy=%b fib=%0d ovf=%b", busy, fib, ovf);
    run_req("after_rst", 6, 8, 0);

    // ena low blocks new requests
    @(posedge clk); #2;
    ena = 1'b0; n = 8'd4; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("ena_off_ignored", dcount, 0);
    $display("stb with ena=0 activity=%0d", dcount);

    // ena dropped mid-computation of n=7
    @(posedge clk); #2;
    ena = 1'b1; n = 8'd7; stb = 1'b1;
    @(posedge clk); #2;
    stb = 1'b0;
    @(posedge clk); #2 ena = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("ena_mid_done", int'(seen), 1);
    chk("ena_mid_fib", int'(fib), 13);
    $display("ena dropped mid n=7 fib=%0d", fib);
    @(posedge clk); #2 ena = 1'b1;

    // stb held high with n=5: done every 7 cycles
    @(posedge clk); #2;
    n = 8'd5; stb = 1'b1;
    t0 = -1; t1 = -1; t2 = -1;
    dcount = 0;
    for (int i = 0; i < 100 && dcount < 3; i++) begin
      @(negedge clk);
      if (done) begin
        chk("held_fib", int'(fib), 5);
        if (dcount == 0) t0 = cyc;
        else if (dcount == 1) t1 = cyc;
        else t2 = cyc;
        dcount++;
      end
    end
    chk("held_count", dcount, 3);
    chk("held_gap1", t1 - t0, 7);
    chk("held_gap2", t2 - t1, 7);
    $display("stb held n=5 done gaps %0d %0d", t1 - t0, t2 - t1);
    @(posedge clk); #2 stb = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("held_idle", int'(busy), 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fib_engine.md
# fib_engine

Iterative Fibonacci responder: on a one-cycle strobe it latches an index `n`, computes F(n) one iteration per clock, and returns the result on a busy/done handshake. It is the core the project top wraps. `ui_in` drives `n`, `uio_in[0]` drives `stb`, `uo_out` carries `fib`, and `uio_out[1]` carries `busy`. Results wider than the output width saturate, and an overflow flag marks them.

## Interface
- `W`, default 8: result width; F(n) > 2^W−1 saturates.
- `NW`, default 8: index width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `ena`  in  1  design enable; gates only the acceptance of new requests.
- `stb`  in  1  request strobe; sampled on rising `clk`.
- `n`  in  NW  Fibonacci index; sampled with `stb`.
- `busy`  out  1  high while a computation is in progress.
- `done`  out  1  one-cycle pulse when the result updates.
- `fib`  out  W  F(n), saturated to all-ones on overflow.
- `ovf`  out  1  high when F(n) > 2^W−1; valid alongside `fib`.

## Operation
- Two states: IDLE and CALC.
- Internal registers:
  - `a`, `b`: W-bit.
  - `a_ovf`, `b_ovf`: sticky overflow markers.
  - `rem`: NW-bit remaining-iteration counter.
- IDLE:
  - `busy`=0.
  - When `stb`=1 and `ena`=1 on an edge: load `rem`←`n`, `a`←0, `b`←1, `a_ovf`←0, `b_ovf`←0, then go to CALC.
  - Otherwise stay in IDLE.
- CALC, when `rem`≠0, every edge:
  - `a`←`b`, `a_ovf`←`b_ovf`.
  - `b`←sat(`a`+`b`), computed with a W+1-bit sum. The result is all-ones if the sum carries or if either marker is set.
  - `b_ovf`←`b_ovf` | `a_ovf` | carry.
  - `rem`←`rem`−1.
- CALC, when `rem`=0 on an edge:
  - `fib`←`a`, `ovf`←`a_ovf`, `done`←1.
  - Go to IDLE.
- Invariant after i iterations: `a`=F(i) and `b`=F(i+1), each exact or saturated. `ovf` reflects only F(n); it does not reflect F(n+1).
- `stb` while in CALC is ignored. It is not queued, and it does not restart the computation.
- `ena`=0 during CALC: the computation continues and completes normally.
- `fib` and `ovf` hold their last result through IDLE and through the next CALC. They change only at completion.
- `done` is high for exactly one cycle per accepted request.

## Timing
- Reset: on any edge with `rst_n`=0, including mid-CALC, the block enters IDLE with `busy`=0, `done`=0, `fib`=0, `ovf`=0. Internal registers are cleared and the in-flight request is discarded.
- `stb`=1 must not be sampled on the reset edge; a strobe there is ignored.
- Latency, with the request accepted at edge k:
  - `busy`=1 from after edge k through edge k+n.
  - `busy` falls after edge k+n+1, in the same cycle that `fib`, `ovf` and `done` update.
  - `busy` is high for n+1 cycles.
- `n`=0: one cycle of `busy`, then `fib`=0.
- Maximum `n`=2^NW−1: 2^NW cycles busy. `rem` never wraps.
- New request on the edge immediately after completion: accepted. Back-to-back throughput is n+2 cycles per request.
- With `W`=8: F(13)=233 is exact. F(14) and above give `fib`=8'hFF, `ovf`=1.
- `stb` held high continuously: a new request is accepted on every IDLE edge, using the `n` present at that edge.

## Test plan
- Reset, then `n`=0,1,2,…,9 using the stb/busy handshake. Required `fib`=0,1,1,2,3,5,8,13,21,34, with `ovf`=0 and one `done` pulse each.
- `n`=10: `busy` high for exactly 11 cycles after the strobe edge, then `fib`=55. A second `stb` mid-CALC, with `n`=3, is ignored, and `fib` stays 55.
- `n`=13 → `fib`=233, `ovf`=0. `n`=14 → `fib`=255, `ovf`=1. `n`=255 → `busy` for 256 cycles, then `fib`=255, `ovf`=1.
- `rst_n` low for one edge during CALC of `n`=20. Required: `busy`, `done`, `fib` and `ovf` all 0 on the next cycle, no `done` pulse afterwards, and a following `n`=6 request returns 8.
- `ena`=0 with `stb` pulsed: `busy` stays 0 and there is no `done`. `ena` deasserted mid-CALC of `n`=7: the computation still finishes with `fib`=13.
- `stb` held high with `n`=5: successive `done` pulses 7 cycles apart, each with `fib`=5.
